pass_entry: RTL and testbench

//  Keypad-side producer of the 2-digit gate password consumed by the parking FSM.

---
 rtl/pass_entry.sv | 139 +++++++++++++
 tb/tb_pass_entry.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pass_entry.sv
// pass_entry: collects a two-digit keypad password into pass1/pass2 and offers
// it to the parking FSM with a valid/ack handshake once ENTER is pressed.
// Supports clear, an inactivity timeout while digits are pending, and an
// error pulse on illegal key events.
module pass_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_press,
  input  logic [1:0] key_code,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       pass_ack,
  output logic [1:0] pass1,
  output logic [1:0] pass2,
  output logic       pass_valid,
  output logic [1:0] digit_cnt,
  output logic       key_err,
  output logic       timeout
);

  localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ONE, TWO, PRESENT} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] tcnt, tcnt_d;
  logic [1:0]       pass1_d, pass2_d, digit_cnt_d;
  logic             key_err_d, timeout_d;
  logic             press_q, enter_q, clear_q;
  logic             ev_press, ev_enter, ev_clear;
  logic             hit, to_idle;

  // Key events are rising edges of the level inputs.
  assign ev_press   = key_press & ~press_q;
  assign ev_enter   = key_enter & ~enter_q;
  assign ev_clear   = key_clear & ~clear_q;
  assign hit        = (tcnt == LAST);
  assign pass_valid = (state == PRESENT);

  // Next-state, digit capture, timeout count and pulse generation.
  // Priority is clear > press > enter; a winning but illegal event in ONE/TWO
  // does not restart the idle count, and a timeout suppresses its error pulse.
  always_comb begin
    state_d     = state;
    pass1_d     = pass1;
    pass2_d     = pass2;
    digit_cnt_d = digit_cnt;
    key_err_d   = 1'b0;
    timeout_d   = 1'b0;
    tcnt_d      = '0;
    to_idle     = 1'b0;
    case (state)
      IDLE: begin
        if (!ev_clear) begin
          if (ev_press) begin
            pass1_d     = key_code;
            digit_cnt_d = 2'd1;
            state_d     = ONE;
          end else if (ev_enter) begin
            key_err_d = 1'b1;
          end
        end
      end
      ONE: begin
        if (ev_clear) begin
          to_idle = 1'b1;
        end else if (ev_press) begin
          pass2_d     = key_code;
          digit_cnt_d = 2'd2;
          state_d     = TWO;
        end else if (hit) begin
          timeout_d = 1'b1;
          to_idle   = 1'b1;
        end else begin
          tcnt_d    = tcnt + CNT_W'(1);
          key_err_d = ev_enter;
        end
      end
      TWO: begin
        if (ev_clear) begin
          to_idle = 1'b1;
        end else if (ev_enter && !ev_press) begin
          state_d = PRESENT;
        end else if (hit) begin
          timeout_d = 1'b1;
          to_idle   = 1'b1;
        end else begin
          tcnt_d    = tcnt + CNT_W'(1);
          key_err_d = ev_press;
        end
      end
      PRESENT: begin
        if (ev_clear || pass_ack) begin
          to_idle = 1'b1;
        end else if (ev_press || ev_enter) begin
          key_err_d = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase
    if (to_idle) begin
      state_d     = IDLE;
      pass1_d     = '0;
      pass2_d     = '0;
      digit_cnt_d = '0;
    end
  end

  // State, datapath and edge-detect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      pass1     <= '0;
      pass2     <= '0;
      digit_cnt <= '0;
      key_err   <= 1'b0;
      timeout   <= 1'b0;
      tcnt      <= '0;
      press_q   <= 1'b0;
      enter_q   <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state     <= state_d;
      pass1     <= pass1_d;
      pass2     <= pass2_d;
      digit_cnt <= digit_cnt_d;
      key_err   <= key_err_d;
      timeout   <= timeout_d;
      tcnt      <= tcnt_d;
      press_q   <= key_press;
      enter_q   <= key_enter;
      clear_q   <= key_clear;
    end
  end

endmodule

// File: tb/tb_pass_entry.sv
// Testbench for pass_entry: directed scenarios plus a randomized run checked
// against a queue-based model of the password entry rules.
module tb_pass_entry;

  localparam int unsigned TMO = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_press = 1'b0;
  logic [1:0] key_code = '0;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic       pass_ack = 1'b0;
  logic [1:0] pass1, pass2, digit_cnt;
  logic       pass_valid, key_err, timeout;

  int tests = 0;
  int fails = 0;

  pass_entry #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .key_press(key_press), .key_code(key_code),
    .key_enter(key_enter), .key_clear(key_clear), .pass_ack(pass_ack),
    .pass1(pass1), .pass2(pass2), .pass_valid(pass_valid),
    .digit_cnt(digit_cnt), .key_err(key_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: held digits as a queue, a presenting flag, idle count.
  int unsigned m_digits[$];
  bit          m_present, m_err, m_to;
  int unsigned m_idle;
  bit          pp, pe, pc;

  task automatic model_step();
    bit ep, ee, ec;
    int ev;
    if (!reset_n) begin
      m_digits.delete();
      m_present = 0; m_err = 0; m_to = 0; m_idle = 0;
      pp = 0; pe = 0; pc = 0;
      return;
    end
    ep = key_press && !pp;
    ee = key_enter && !pe;
    ec = key_clear && !pc;
    pp = key_press; pe = key_enter; pc = key_clear;
    m_err = 0; m_to = 0;
    ev = ec ? 1 : ep ? 2 : ee ? 3 : 0;
    if (m_present) begin
      if (ev == 1 || pass_ack) begin m_present = 0; m_digits.delete(); end
      else if (ev != 0) m_err = 1;
    end else if (ev == 1) begin
      m_digits.delete(); m_idle = 0;
    end else if (ev == 2 && m_digits.size() < 2) begin
      m_digits.push_back(int'(key_code)); m_idle = 0;
    end else if (ev == 3 && m_digits.size() == 2) begin
      m_present = 1; m_idle = 0;
    end else begin
      if (m_digits.size() > 0) begin
        if (m_idle == TMO - 1) begin m_to = 1; m_digits.delete(); m_idle = 0; end
        else m_idle++;
      end
      if (ev != 0 && !m_to) m_err = 1;
    end
  endtask

  function automatic logic [8:0] model_out();
    logic [1:0] p1, p2;
    p1 = (m_digits.size() >= 1) ? 2'(m_digits[0]) : 2'd0;
    p2 = (m_digits.size() >= 2) ? 2'(m_digits[1]) : 2'd0;
    return {p1, p2, m_present, 2'(m_digits.size()), m_err, m_to};
  endfunction

  // One clock: model sees the same inputs as the DUT at the edge; outputs
  // are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick(); tick();
    tests++;
    if ({pass1, pass2, pass_valid, digit_cnt, key_err, timeout} !== 9'd0) begin
      fails++;
      $display("FAIL reset_hold: got p1=%0d p2=%0d v=%0d cnt=%0d err=%0d to=%0d, exp all 0",
               pass1, pass2, pass_valid, digit_cnt, key_err, timeout);
    end
    reset_n = 1;
    tick();
    tests++;
    if ({pass1, pass2, pass_valid, digit_cnt, key_err, timeout} !== 9'd0) begin
      fails++;
      $display("FAIL reset_release: got p1=%0d p2=%0d v=%0d cnt=%0d, exp all 0",
               pass1, pass2, pass_valid, digit_cnt);
    end
  endtask

  task automatic test_basic();
    key_code = 2'd1; key_press = 1; tick();
    tests++;
    if (digit_cnt !== 2'd1 || pass1 !== 2'd1) begin
      fails++;
      $display("FAIL basic_digit1: got cnt=%0d p1=%0d, exp cnt=1 p1=1", digit_cnt, pass1);
    end
    key_press = 0; tick();
    key_code = 2'd2; key_press = 1; tick();
    tests++;
    if (digit_cnt !== 2'd2 || pass2 !== 2'd2 || pass_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_digit2: got cnt=%0d p2=%0d v=%0d, exp cnt=2 p2=2 v=0",
               digit_cnt, pass2, pass_valid);
    end
    key_press = 0; tick();
    key_enter = 1; tick();
    tests++;
    if (pass_valid !== 1'b1 || pass1 !== 2'd1 || pass2 !== 2'd2 || key_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_enter: got v=%0d p1=%0d p2=%0d err=%0d, exp v=1 p1=1 p2=2 err=0",
               pass_valid, pass1, pass2, key_err);
    end
    key_enter = 0; tick();
    pass_ack = 1; tick();
    pass_ack = 0;
    tests++;
    if (pass_valid !== 1'b0 || pass1 !== 2'd0 || pass2 !== 2'd0 || digit_cnt !== 2'd0) begin
      fails++;
      $display("FAIL basic_ack: got v=%0d p1=%0d p2=%0d cnt=%0d, exp all 0",
               pass_valid, pass1, pass2, digit_cnt);
    end
    tick();
  endtask

  task automatic test_held_press();
    bit saw_err = 0;
    key_code = 2'd3; key_press = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (key_err) saw_err = 1;
    end
    tests++;
    if (digit_cnt !== 2'd1 || pass1 !== 2'd3 || pass2 !== 2'd0 || saw_err) begin
      fails++;
      $display("FAIL held_press: got cnt=%0d p1=%0d p2=%0d err_seen=%0d, exp cnt=1 p1=3 p2=0 err_seen=0",
               digit_cnt, pass1, pass2, saw_err);
    end
    key_press = 0; tick();
    key_clear = 1; tick();
    key_clear = 0; tick();
    tests++;
    if (digit_cnt !== 2'd0 || pass1 !== 2'd0) begin
      fails++;
      $display("FAIL held_clear: got cnt=%0d p1=%0d, exp cnt=0 p1=0", digit_cnt, pass1);
    end
  endtask

  task automatic test_timeout();
    bit early = 0;
    key_code = 2'd2; key_press = 1; tick();
    key_press = 0;
    for (int k = 1; k < 100; k++) begin
      tick();
      if (timeout || digit_cnt !== 2'd1) early = 1;
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL timeout_early: got early timeout or lost digit, exp none before cycle 100");
    end
    tick();
    tests++;
    if (timeout !== 1'b1 || digit_cnt !== 2'd0 || pass1 !== 2'd0 || key_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_fire: got to=%0d cnt=%0d p1=%0d err=%0d, exp to=1 cnt=0 p1=0 err=0",
               timeout, digit_cnt, pass1, key_err);
    end
    tick();
    tests++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse_width: got to=%0d, exp 0", timeout);
    end
    // Restart: second press on cycle 99 resets the idle count.
    early = 0;
    key_code = 2'd0; key_press = 1; tick();
    key_press = 0;
    for (int k = 1; k < 99; k++) begin
      tick();
      if (timeout) early = 1;
    end
    key_code = 2'd1; key_press = 1; tick();
    key_press = 0;
    tests++;
    if (digit_cnt !== 2'd2 || pass2 !== 2'd1 || timeout !== 1'b0 || early) begin
      fails++;
      $display("FAIL timeout_restart_press: got cnt=%0d p2=%0d to=%0d early=%0d, exp cnt=2 p2=1 to=0 early=0",
               digit_cnt, pass2, timeout, early);
    end
    for (int k = 1; k < 100; k++) begin
      tick();
      if (timeout) early = 1;
    end
    tests++;
    if (early || digit_cnt !== 2'd2) begin
      fails++;
      $display("FAIL timeout_restart_count: got early=%0d cnt=%0d, exp early=0 cnt=2", early, digit_cnt);
    end
    tick();
    tests++;
    if (timeout !== 1'b1 || digit_cnt !== 2'd0) begin
      fails++;
      $display("FAIL timeout_two: got to=%0d cnt=%0d, exp to=1 cnt=0", timeout, digit_cnt);
    end
    tick();
  endtask

  task automatic test_errors();
    key_code = 2'd1; key_press = 1; tick();
    key_press = 0; tick();
    key_enter = 1; tick();
    tests++;
    if (key_err !== 1'b1 || digit_cnt !== 2'd1 || pass_valid !== 1'b0) begin
      fails++;
      $display("FAIL err_enter_one: got err=%0d cnt=%0d v=%0d, exp err=1 cnt=1 v=0",
               key_err, digit_cnt, pass_valid);
    end
    key_enter = 0; tick();
    tests++;
    if (key_err !== 1'b0 || digit_cnt !== 2'd1) begin
      fails++;
      $display("FAIL err_pulse_width: got err=%0d cnt=%0d, exp err=0 cnt=1", key_err, digit_cnt);
    end
    key_code = 2'd2; key_press = 1; tick();
    key_press = 0; tick();
    key_code = 2'd3; key_press = 1; tick();
    tests++;
    if (key_err !== 1'b1 || pass2 !== 2'd2 || digit_cnt !== 2'd2) begin
      fails++;
      $display("FAIL err_press_two: got err=%0d p2=%0d cnt=%0d, exp err=1 p2=2 cnt=2",
               key_err, pass2, digit_cnt);
    end
    key_press = 0; tick();
    key_clear = 1; tick();
    key_clear = 0; tick();
  endtask

  task automatic test_press_clear();
    key_code = 2'd0; key_press = 1; tick();
    key_press = 0; tick();
    key_code = 2'd3; key_press = 1; key_clear = 1; tick();
    tests++;
    if (digit_cnt !== 2'd0 || key_err !== 1'b0 || pass1 !== 2'd0 || pass2 !== 2'd0) begin
      fails++;
      $display("FAIL press_clear: got cnt=%0d err=%0d p1=%0d p2=%0d, exp all 0",
               digit_cnt, key_err, pass1, pass2);
    end
    key_press = 0; key_clear = 0; tick();
  endtask

  task automatic test_reset_present();
    key_code = 2'd3; key_press = 1; tick();
    key_press = 0; tick();
    key_code = 2'd1; key_press = 1; tick();
    key_press = 0; tick();
    key_enter = 1; tick();
    key_enter = 0; tick();
    tests++;
    if (pass_valid !== 1'b1 || pass1 !== 2'd3 || pass2 !== 2'd1) begin
      fails++;
      $display("FAIL present_setup: got v=%0d p1=%0d p2=%0d, exp v=1 p1=3 p2=1",
               pass_valid, pass1, pass2);
    end
    reset_n = 0; pass_ack = 1; tick();
    reset_n = 1; pass_ack = 0;
    tests++;
    if ({pass1, pass2, pass_valid, digit_cnt, key_err, timeout} !== 9'd0) begin
      fails++;
      $display("FAIL reset_present: got p1=%0d p2=%0d v=%0d cnt=%0d err=%0d to=%0d, exp all 0",
               pass1, pass2, pass_valid, digit_cnt, key_err, timeout);
    end
    tick();
    tests++;
    if ({pass1, pass2, pass_valid, digit_cnt, key_err, timeout} !== 9'd0) begin
      fails++;
      $display("FAIL reset_present_after: got p1=%0d p2=%0d v=%0d cnt=%0d, exp all 0",
               pass1, pass2, pass_valid, digit_cnt);
    end
  endtask

  task automatic test_random();
    logic [8:0] got, exp;
    reset_n = 0; key_press = 0; key_enter = 0; key_clear = 0; pass_ack = 0;
    tick();
    reset_n = 1;
    for (int c = 0; c < 4000; c++) begin
      if ((c % 400) < 280) begin
        if ($urandom_range(5) == 0) key_press = ~key_press;
        key_code = 2'($urandom_range(3));
        if ($urandom_range(11) == 0) key_enter = ~key_enter;
        if ($urandom_range(39) == 0) key_clear = ~key_clear;
        pass_ack = ($urandom_range(3) == 0);
        reset_n  = ($urandom_range(299) != 0);
      end else begin
        reset_n  = 1;
        pass_ack = 0;
      end
      tick();
      got = {pass1, pass2, pass_valid, digit_cnt, key_err, timeout};
      exp = model_out();
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random_cycle_%0d: got {p1,p2,v,cnt,err,to}=%b, exp %b", c, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_press();
    test_timeout();
    test_errors();
    test_press_clear();
    test_reset_present();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
